pipe_perf_monitor: RTL

PIPE_PERF_MONITOR -- requirements
Module: pipe_perf_monitor

---
 rtl/perf_pkg.sv | 5 +
 rtl/perf_cnt.sv | 24 ++
 rtl/pipe_perf_monitor.sv | 75 +++++++
 3 files changed

// File: rtl/perf_pkg.sv
// perf_pkg: shared state encoding and read-index constants for pipe_perf_monitor
package perf_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;
  localparam logic [3:0] RD_CYCLE = 4'd0;
endpackage

// File: rtl/perf_cnt.sv
// perf_cnt: single CNT_W event counter with saturate-or-wrap and sticky overflow
module perf_cnt #(
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      cnt <= (&cnt && SAT_MODE != 0) ? cnt : cnt + 1'b1;
      ovf <= ovf | &cnt;
    end
endmodule

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: cycle and per-channel event counters with run control,
// cycle-limit freeze, snapshot bank and registered read port
module pipe_perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int SAT_MODE    = 1,
  parameter int CYCLE_LIMIT = 30
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              snap_i,
  input  logic              rd_snap_i,
  input  logic [3:0]        rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [NUM_CH:0]   ovf_o,
  output logic              snap_valid_o,
  output logic              done_o
);
  state_t state, state_nxt;
  logic count;
  logic [NUM_CH:0] inc;
  logic [CNT_W-1:0] live [NUM_CH+1];
  logic [CNT_W-1:0] snap_bank [NUM_CH+1];
  logic [CNT_W-1:0] rd_nxt;
  // en_i low pauses counting immediately, even on the RUN->IDLE edge
  assign count = state == RUN && en_i;
  assign inc = {(NUM_CH+1){count}} & {event_i, 1'b1};
  assign done_o = state == FROZEN;
  always_ff @(posedge clk_i or negedge start_i)
    if (!start_i) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (clr_i) state_nxt = IDLE;
    else if (state == IDLE && en_i) state_nxt = RUN;
    else if (state == RUN && !en_i) state_nxt = IDLE;
    else if (state == RUN && CYCLE_LIMIT != 0 && live[0] + 1'b1 == CNT_W'(CYCLE_LIMIT)) state_nxt = FROZEN;
  end
  for (genvar g = 0; g <= NUM_CH; g++) begin : g_cnt
    perf_cnt #(.CNT_W(CNT_W), .SAT_MODE(SAT_MODE)) u_cnt (
      .clk(clk_i),
      .rst_n(start_i),
      .clr(clr_i),
      .inc(inc[g]),
      .cnt(live[g]),
      .ovf(ovf_o[g])
    );
  end
  always_comb begin
    rd_nxt = '0;
    for (int k = 0; k <= NUM_CH; k++)
      if (rd_sel_i == RD_CYCLE + 4'(k)) rd_nxt = rd_snap_i ? snap_bank[k] : live[k];
  end
  // snapshot captures the pre-increment values seen on this edge
  always_ff @(posedge clk_i or negedge start_i)
    if (!start_i) begin
      for (int k = 0; k <= NUM_CH; k++) snap_bank[k] <= '0;
      snap_valid_o <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_data_o <= rd_nxt;
      if (clr_i) begin
        for (int k = 0; k <= NUM_CH; k++) snap_bank[k] <= '0;
        snap_valid_o <= 1'b0;
      end else if (snap_i) begin
        for (int k = 0; k <= NUM_CH; k++) snap_bank[k] <= live[k];
        snap_valid_o <= 1'b1;
      end
    end
endmodule
